// File: rtl/uart_pkg.sv
// Shared types, register addresses and parity helper for the
// FIFO-buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } tx_state_e;

    localparam logic [7:0] ADDR_THR = 8'h00;
    localparam logic [7:0] ADDR_LCR = 8'h04;
    localparam logic [7:0] ADDR_DLL = 8'h08;
    localparam logic [7:0] ADDR_DLM = 8'h0C;
    localparam logic [7:0] ADDR_LSR = 8'h10;
    localparam logic [7:0] ADDR_LVL = 8'h14;
    localparam logic [7:0] ADDR_FCR = 8'h18;

    // Bit 7 of LCR is reserved and not stored.
    typedef struct packed {
        logic       brk;
        logic       stick;
        logic       eps;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } lcr_t;

    // Parity over the 5+wls active bits; stick forces the
    // inverse of eps regardless of data.
    function automatic logic calc_parity(
        logic [7:0] d,
        logic [1:0] wls,
        logic       eps,
        logic       stick
    );
        logic [7:0] m;
        logic       x;
        m = 8'hFF >> (2'd3 - wls);
        x = ^(d & m);
        if (stick) return ~eps;
        return eps ? x : ~x;
    endfunction

endpackage

// File: rtl/uart_apb_tx_fifo_if.sv
// APB bus bundle for the UART transmitter.
// Ports: PSEL/PENABLE/PWRITE/PADDR/PWDATA from master; PRDATA/PREADY/PSLVERR from slave.
interface uart_apb_tx_fifo_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush and same-cycle push/pop.
// Ports: clk, rst, push/wdata, pop/rdata (show-ahead), flush, full, empty, level.
module uart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = mem[rptr];
    // Full is checked before any pop of the same cycle.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (!do_push && do_pop) level <= level - LW'(1);
        end
    end
endmodule

// File: rtl/uart_apb_tx_fifo.sv
// FIFO-buffered UART transmitter with APB registers and DMA request.
// Ports: PCLK, PRESET, apb (slave), UART_SOUT, TXDRDYn (active-low DMA request).
module uart_apb_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TX_LOW_WM  = 4,
    parameter int DIV_W      = 16,
    parameter int DIV_RST    = 1
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    uart_apb_tx_fifo_if.slave    apb,
    output logic                 UART_SOUT,
    output logic                 TXDRDYn
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] LOW_WM = LW'(TX_LOW_WM);

    lcr_t             lcr;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] cnt;
    logic             tick;
    logic             ovr;

    logic             access, wr, rd;
    logic             thr_wr, flush, div_wr, mapped;
    logic             push, pop;
    logic [7:0]       head;
    logic             full, empty;
    logic [LW-1:0]    level;

    tx_state_e        state;
    logic [7:0]       shreg;
    logic [2:0]       bitcnt;
    logic [1:0]       f_wls;
    logic             f_pen, f_stb, f_par;
    logic             last_stop;
    logic             line;
    logic             temt;

    assign access = apb.PSEL & apb.PENABLE;
    assign wr     = access & apb.PWRITE;
    assign rd     = access & ~apb.PWRITE;
    assign thr_wr = wr & (apb.PADDR == ADDR_THR);
    assign flush  = wr & (apb.PADDR == ADDR_FCR) & apb.PWDATA[0];
    assign div_wr = wr & ((apb.PADDR == ADDR_DLL) | (apb.PADDR == ADDR_DLM));
    assign mapped = apb.PADDR inside {ADDR_THR, ADDR_LCR, ADDR_DLL,
                                      ADDR_DLM, ADDR_LSR, ADDR_LVL, ADDR_FCR};
    assign push   = thr_wr & ~full & ~flush;
    assign temt   = empty & (state == S_IDLE);

    assign apb.PREADY = 1'b1;

    always_comb begin
        apb.PRDATA  = 8'h00;
        apb.PSLVERR = 1'b0;
        if (access) begin
            apb.PSLVERR = ~mapped | (thr_wr & full & ~flush);
        end
        if (rd) begin
            unique case (apb.PADDR)
                ADDR_LCR: apb.PRDATA = {1'b0, lcr};
                ADDR_DLL: apb.PRDATA = div[7:0];
                ADDR_DLM: apb.PRDATA = div[15:8];
                ADDR_LSR: apb.PRDATA = {4'h0, ovr, temt, full, empty};
                ADDR_LVL: apb.PRDATA = 8'(level);
                default:  apb.PRDATA = 8'h00;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            lcr <= lcr_t'(7'h03);
            div <= DIV_W'(DIV_RST);
            ovr <= 1'b0;
        end else begin
            if (wr) begin
                unique case (apb.PADDR)
                    ADDR_LCR: lcr        <= lcr_t'(apb.PWDATA[6:0]);
                    ADDR_DLL: div[7:0]   <= apb.PWDATA;
                    ADDR_DLM: div[15:8]  <= apb.PWDATA;
                    default:  ;
                endcase
            end
            if (thr_wr && full && !flush)
                ovr <= 1'b1;
            else if (rd && apb.PADDR == ADDR_LSR)
                ovr <= 1'b0;
        end
    end

    // A zero divisor runs at the same rate as one.
    assign div_eff = (div == '0) ? DIV_W'(1) : div;
    assign tick    = (cnt == div_eff - DIV_W'(1));

    always_ff @(posedge PCLK) begin
        if (PRESET || div_wr) cnt <= '0;
        else if (tick)        cnt <= '0;
        else                  cnt <= cnt + DIV_W'(1);
    end

    uart_sync_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (push),
        .wdata (apb.PWDATA),
        .pop   (pop),
        .flush (flush),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign last_stop = (state == S_STOP2) || (state == S_STOP1 && !f_stb);
    // Pop from IDLE or straight out of the final stop bit.
    assign pop = tick & ~empty & ~flush & ((state == S_IDLE) | last_stop);

    always_comb begin
        line = 1'b1;
        unique case (state)
            S_START:  line = 1'b0;
            S_DATA:   line = shreg[0];
            S_PARITY: line = f_par;
            default:  line = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            f_wls     <= '0;
            f_pen     <= 1'b0;
            f_stb     <= 1'b0;
            f_par     <= 1'b0;
            UART_SOUT <= 1'b1;
            TXDRDYn   <= 1'b1;
        end else begin
            UART_SOUT <= lcr.brk ? 1'b0 : line;
            TXDRDYn   <= ~(level <= LOW_WM);
            if (pop) begin
                state <= S_START;
                shreg <= head;
                f_wls <= lcr.wls;
                f_pen <= lcr.pen;
                f_stb <= lcr.stb;
                f_par <= calc_parity(head, lcr.wls, lcr.eps, lcr.stick);
            end else if (tick) begin
                unique case (state)
                    S_START: begin
                        state  <= S_DATA;
                        bitcnt <= '0;
                    end
                    S_DATA: begin
                        shreg <= shreg >> 1;
                        if (bitcnt == 3'd4 + {1'b0, f_wls})
                            state <= f_pen ? S_PARITY : S_STOP1;
                        else
                            bitcnt <= bitcnt + 3'd1;
                    end
                    S_PARITY: state <= S_STOP1;
                    S_STOP1:  state <= f_stb ? S_STOP2 : S_IDLE;
                    S_STOP2:  state <= S_IDLE;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_apb_tx_fifo.sv
// Directed testbench for uart_apb_tx_fifo.
// Drives APB transfers and samples UART_SOUT mid-bit.
module tb_uart_apb_tx_fifo;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sout;
    logic drq;
    int   checks = 0;
    int   failures = 0;

    uart_apb_tx_fifo_if bus ();

    uart_apb_tx_fifo #(
        .FIFO_DEPTH (16),
        .TX_LOW_WM  (4),
        .DIV_W      (16),
        .DIV_RST    (1)
    ) dut (
        .PCLK      (clk),
        .PRESET    (rst),
        .apb       (bus),
        .UART_SOUT (sout),
        .TXDRDYn   (drq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] d,
                          output logic err);
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PENABLE = 1'b0;
        bus.PADDR = a; bus.PWDATA = d;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        #1 err = bus.PSLVERR;
        @(negedge clk);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [7:0] d,
                          output logic err);
        @(negedge clk);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PENABLE = 1'b0;
        bus.PADDR = a;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        #1 d = bus.PRDATA; err = bus.PSLVERR;
        @(negedge clk);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    // Wait for the start-bit edge, then sample n bits mid-period
    // (divisor 4 assumed).
    task automatic capture(input int n, output logic [39:0] bits,
                           output logic ok);
        bits = '0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (sout === 1'b0) begin ok = 1'b1; break; end
        end
        if (ok) begin
            repeat (2) @(posedge clk);
            #1 bits[0] = sout;
            for (int i = 1; i < n; i++) begin
                repeat (4) @(posedge clk);
                #1 bits[i] = sout;
            end
        end
    endtask

    task automatic wait_temt(input string tag);
        logic [7:0] v;
        logic       e;
        v = 8'h00;
        for (int i = 0; i < 100; i++) begin
            apb_rd(ADDR_LSR, v, e);
            if (v[2]) break;
        end
        chk(tag, v[2], 1'b1);
    endtask

    function automatic logic [10:0] frm2(input logic [7:0] d);
        return {2'b11, d, 1'b0};
    endfunction

    logic [7:0]  rv;
    logic        err;
    logic        ok;
    logic [39:0] bits;

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 8'h00; bus.PWDATA = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sout", sout, 1'b1);
        chk("rst_drq", drq, 1'b1);
        chk("rst_prdata", bus.PRDATA, 8'h00);
        chk("rst_pslverr", bus.PSLVERR, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("drq_after_rst", drq, 1'b0);

        apb_rd(ADDR_LCR, rv, err);
        chk("lcr_rst", rv, 8'h03);
        chk("lcr_rd_err", err, 1'b0);
        apb_rd(ADDR_LSR, rv, err);
        chk("lsr_rst", rv, 8'h05);
        apb_rd(ADDR_LVL, rv, err);
        chk("lvl_rst", rv, 8'h00);
        apb_rd(8'h1C, rv, err);
        chk("unmapped_err", err, 1'b1);
        apb_rd(ADDR_THR, rv, err);
        chk("thr_rd_zero", rv, 8'h00);

        // 8N1 frame of 0xA5 at divisor 4
        apb_wr(ADDR_DLL, 8'h04, err);
        apb_rd(ADDR_DLL, rv, err);
        chk("dll_rd", rv, 8'h04);
        apb_wr(ADDR_THR, 8'hA5, err);
        chk("thr_err", err, 1'b0);
        capture(10, bits, ok);
        chk("a5_start_seen", ok, 1'b1);
        chk("a5_bits", bits[9:0], 10'h34A);
        wait_temt("a5_temt");

        // even parity, 0x07 -> parity 1
        apb_wr(ADDR_LCR, 8'h1B, err);
        apb_wr(ADDR_THR, 8'h07, err);
        capture(11, bits, ok);
        chk("even_start_seen", ok, 1'b1);
        chk("even_par", bits[9], 1'b1);
        chk("even_frame", bits[10:0], 11'h60E);
        wait_temt("even_temt");

        // stick parity with EPS=1 -> parity 0
        apb_wr(ADDR_LCR, 8'h3B, err);
        apb_wr(ADDR_THR, 8'h07, err);
        capture(11, bits, ok);
        chk("stick_par", bits[9], 1'b0);
        chk("stick_frame", bits[10:0], 11'h40E);
        wait_temt("stick_temt");

        // fill FIFO with a very slow baud, then overflow
        apb_wr(ADDR_LCR, 8'h03, err);
        apb_wr(ADDR_DLL, 8'hFF, err);
        apb_wr(ADDR_DLM, 8'hFF, err);
        for (int i = 0; i < 16; i++) begin
            apb_wr(ADDR_THR, 8'(i), err);
            chk("fill_err", err, 1'b0);
            @(posedge clk); #1;
            if (i == 3) chk("drq_lvl4", drq, 1'b0);
            if (i == 4) chk("drq_lvl5", drq, 1'b1);
        end
        apb_rd(ADDR_LVL, rv, err);
        chk("lvl_full", rv, 8'h10);
        apb_wr(ADDR_THR, 8'hEE, err);
        chk("ovf_pslverr", err, 1'b1);
        apb_rd(ADDR_LVL, rv, err);
        chk("lvl_after_ovf", rv, 8'h10);
        apb_rd(ADDR_LSR, rv, err);
        chk("lsr_ovr_set", rv, 8'h0A);
        apb_rd(ADDR_LSR, rv, err);
        chk("lsr_ovr_clr", rv, 8'h02);
        apb_wr(ADDR_FCR, 8'h01, err);
        chk("fcr_err", err, 1'b0);
        apb_rd(ADDR_LVL, rv, err);
        chk("lvl_flushed", rv, 8'h00);
        apb_rd(ADDR_LSR, rv, err);
        chk("lsr_flushed", rv, 8'h05);
        chk("drq_flushed", drq, 1'b0);

        // three back-to-back 8N2 frames
        apb_wr(ADDR_LCR, 8'h07, err);
        apb_wr(ADDR_THR, 8'h55, err);
        apb_wr(ADDR_THR, 8'h00, err);
        apb_wr(ADDR_THR, 8'hF0, err);
        apb_rd(ADDR_LVL, rv, err);
        chk("lvl_three", rv, 8'h03);
        apb_wr(ADDR_DLM, 8'h00, err);
        apb_wr(ADDR_DLL, 8'h04, err);
        capture(34, bits, ok);
        chk("b2b_start_seen", ok, 1'b1);
        chk("b2b_bits", bits[32:0],
            {frm2(8'hF0), frm2(8'h00), frm2(8'h55)});
        chk("b2b_idle_after", bits[33], 1'b1);
        wait_temt("b2b_temt");

        // break mid-frame, then flush the queued byte
        apb_wr(ADDR_LCR, 8'h03, err);
        apb_wr(ADDR_THR, 8'hFF, err);
        apb_wr(ADDR_THR, 8'hFF, err);
        capture(1, bits, ok);
        chk("brk_start_seen", ok, 1'b1);
        repeat (4) @(posedge clk);
        #1 chk("brk_pre_sout", sout, 1'b1);
        apb_wr(ADDR_LCR, 8'h43, err);
        @(posedge clk); #1;
        chk("brk_sout", sout, 1'b0);
        apb_rd(ADDR_LVL, rv, err);
        chk("brk_lvl", rv, 8'h01);
        apb_wr(ADDR_FCR, 8'h01, err);
        apb_rd(ADDR_LVL, rv, err);
        chk("brk_lvl_flush", rv, 8'h00);
        apb_rd(ADDR_LSR, rv, err);
        chk("brk_busy", rv[2], 1'b0);
        wait_temt("brk_temt");
        chk("brk_hold", sout, 1'b0);
        apb_wr(ADDR_LCR, 8'h03, err);
        @(posedge clk); #1;
        chk("brk_release", sout, 1'b1);

        // reset in the middle of a frame
        apb_wr(ADDR_THR, 8'h00, err);
        capture(1, bits, ok);
        chk("mid_start_seen", ok, 1'b1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_sout", sout, 1'b1);
        @(negedge clk) rst = 1'b0;
        apb_rd(ADDR_DLL, rv, err);
        chk("mid_rst_dll", rv, 8'h01);
        apb_rd(ADDR_LSR, rv, err);
        chk("mid_rst_lsr", rv, 8'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
